// File: rtl/disp_pkg.sv
// Shared definitions for scanned 7-segment display monitors.
package disp_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned HEX_W      = NUM_DIGITS * NIB_W;
   localparam int unsigned SEG_W      = 7;

   // Active-low gfedcba patterns, indexed by hex value.
   localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } scan_state_e;

   // Exactly one digit enable driven low.
   function automatic logic an_onehot_low(input logic [NUM_DIGITS-1:0] an);
      return ($countones(~an) == 1);
   endfunction

   // More than one digit enable driven low: a bus fault.
   function automatic logic an_multi_low(input logic [NUM_DIGITS-1:0] an);
      return ($countones(~an) > 1);
   endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low 7-segment pattern back to a hex nibble.
module seg7_to_hex
   import disp_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [NIB_W-1:0] nibble,
   output logic             blank,
   output logic             illegal
);

   // Table lookup; anything not in the table and not blank is illegal.
   always_comb begin
      nibble  = '0;
      blank   = (seg == SEG_BLANK);
      illegal = ~blank;
      for (int unsigned i = 0; i < 16; i++) begin
         if (seg == SEG_HEX[i]) begin
            nibble  = NIB_W'(i);
            illegal = 1'b0;
         end
      end
   end

endmodule

// File: rtl/disp_scan_decoder.sv
// Samples a multiplexed AN/SEGMENT display bus and rebuilds the displayed frame.
module disp_scan_decoder
   import disp_pkg::*;
#(
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 2**20
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic [NUM_DIGITS-1:0] AN,
   input  logic [7:0]            SEGMENT,
   output logic [HEX_W-1:0]      HEXS,
   output logic [NUM_DIGITS-1:0] points,
   output logic [NUM_DIGITS-1:0] LES,
   output logic                  frame_vld,
   output logic                  err,
   output logic                  stale
);

   localparam int unsigned STAB_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

   logic [NUM_DIGITS-1:0] r_an, p_an;
   logic [7:0]            r_seg, p_seg;
   logic [STAB_W-1:0]     stab_cnt;
   logic [IDLE_W-1:0]     idle_cnt, idle_nxt;
   scan_state_e           state, state_nxt;

   logic                  changed_c, stable_c, capture_c, multi_c, cap_err_c, frame_done_c;
   logic [NIB_W-1:0]      dec_nibble;
   logic                  dec_blank, dec_illegal;

   logic [HEX_W-1:0]      shadow_hex, sh_hex_nxt;
   logic [NUM_DIGITS-1:0] shadow_pts, sh_pts_nxt;
   logic [NUM_DIGITS-1:0] shadow_les, sh_les_nxt;
   logic [NUM_DIGITS-1:0] seen, seen_nxt;

   seg7_to_hex u_dec (
      .seg     (r_seg[6:0]),
      .nibble  (dec_nibble),
      .blank   (dec_blank),
      .illegal (dec_illegal)
   );

   assign changed_c = ({r_an, r_seg} != {p_an, p_seg});
   assign stable_c  = ~changed_c && (stab_cnt == STAB_MAX);

   // Input registers plus a one-cycle history for change detection.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_an  <= '1;
         r_seg <= '1;
         p_an  <= '1;
         p_seg <= '1;
      end else begin
         r_an  <= AN;
         r_seg <= SEGMENT;
         p_an  <= r_an;
         p_seg <= r_seg;
      end
   end

   // Stability counter: restarts on any bus change, saturates at the capture threshold.
   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         stab_cnt <= '0;
      else if (changed_c)
         stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
         stab_cnt <= stab_cnt + STAB_W'(1);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         state <= SETTLE;
      else
         state <= state_nxt;
   end

   // FSM next state: one capture per digit phase, rearm on the next bus change.
   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE:  if (capture_c) state_nxt = HOLD;
         HOLD:    if (changed_c) state_nxt = SETTLE;
         default: state_nxt = SETTLE;
      endcase
   end

   // FSM outputs: capture strobe and multi-digit fault strobe.
   always_comb begin
      capture_c = 1'b0;
      multi_c   = stable_c && an_multi_low(r_an);
      if (state == SETTLE)
         capture_c = stable_c && an_onehot_low(r_an);
   end

   // Shadow buffer update for the digit being captured.
   always_comb begin
      sh_hex_nxt = shadow_hex;
      sh_pts_nxt = shadow_pts;
      sh_les_nxt = shadow_les;
      seen_nxt   = seen;
      cap_err_c  = 1'b0;
      if (capture_c) begin
         cap_err_c = dec_illegal;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an[i]) begin
               seen_nxt[i]   = 1'b1;
               sh_pts_nxt[i] = ~r_seg[7];
               if (dec_blank) begin
                  sh_les_nxt[i] = 1'b1;
               end else begin
                  sh_les_nxt[i] = 1'b0;
                  sh_hex_nxt[NIB_W*i +: NIB_W] = dec_illegal ? '0 : dec_nibble;
               end
            end
         end
      end
   end

   assign frame_done_c = (seen_nxt == '1);

   // Shadow state; seen clears when the frame is published.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         shadow_hex <= '0;
         shadow_pts <= '0;
         shadow_les <= '1;
         seen       <= '0;
      end else begin
         shadow_hex <= sh_hex_nxt;
         shadow_pts <= sh_pts_nxt;
         shadow_les <= sh_les_nxt;
         seen       <= frame_done_c ? '0 : seen_nxt;
      end
   end

   // Published frame and its strobe, including the completing digit.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         HEXS      <= '0;
         points    <= '0;
         LES       <= '1;
         frame_vld <= 1'b0;
      end else begin
         frame_vld <= frame_done_c;
         if (frame_done_c) begin
            HEXS   <= sh_hex_nxt;
            points <= sh_pts_nxt;
            LES    <= sh_les_nxt;
         end
      end
   end

   // Sticky fault flag.
   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         err <= 1'b0;
      else if (cap_err_c || multi_c)
         err <= 1'b1;
   end

   // Idle counter next value: cleared by a capture, saturating at the timeout.
   always_comb begin
      idle_nxt = idle_cnt;
      if (capture_c)
         idle_nxt = '0;
      else if (idle_cnt != IDLE_MAX)
         idle_nxt = idle_cnt + IDLE_W'(1);
   end

   // Idle counter and stale flag.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         idle_cnt <= '0;
         stale    <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt;
         stale    <= (idle_nxt == IDLE_MAX);
      end
   end

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Directed bench for disp_scan_decoder: drives a DispNum-style scan and checks decoded frames.
module tb_disp_scan_decoder;

   logic        clk = 1'b0;
   logic        RST;
   logic [3:0]  AN;
   logic [7:0]  SEGMENT;
   logic [15:0] HEXS;
   logic [3:0]  points;
   logic [3:0]  LES;
   logic        frame_vld;
   logic        err;
   logic        stale;

   int n_vec  = 0;
   int n_err  = 0;
   int fv_cnt = 0;
   int fv_ref;

   // Active-low gfedcba hex patterns.
   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   disp_scan_decoder #(.STABLE_CYC(4), .TIMEOUT(64)) dut (
      .clk       (clk),
      .RST       (RST),
      .AN        (AN),
      .SEGMENT   (SEGMENT),
      .HEXS      (HEXS),
      .points    (points),
      .LES       (LES),
      .frame_vld (frame_vld),
      .err       (err),
      .stale     (stale)
   );

   always #5 clk = ~clk;

   // Count frame strobes away from the active edge.
   always @(negedge clk) if (frame_vld === 1'b1) fv_cnt++;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_digit(input int idx, input logic [7:0] seg, input int n);
      AN      = ~(4'b0001 << idx);
      SEGMENT = seg;
      tick(n);
   endtask

   task automatic blank_bus(input int n);
      AN      = 4'hF;
      SEGMENT = 8'hFF;
      tick(n);
   endtask

   function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dp);
      return {~dp, seg_tab[nib]};
   endfunction

   // One full scan, 8 cycles per digit + 2 blanking; digits in blank_mask drive all-off.
   task automatic scan(input logic [15:0] hexs, input logic [3:0] pts, input logic [3:0] blank_mask);
      logic [15:0] h;
      h = hexs;
      for (int d = 0; d < 4; d++) begin
         if (blank_mask[d])
            drive_digit(d, {~pts[d], 7'h7F}, 8);
         else
            drive_digit(d, seg_of(h[4*d +: 4], pts[d]), 8);
         blank_bus(2);
      end
   endtask

   initial begin
      RST     = 1'b1;
      AN      = 4'hF;
      SEGMENT = 8'hFF;
      tick(3);

      // Reset state
      chk("rst_hexs",  HEXS,             16'h0000);
      chk("rst_pts",   16'(points),      16'h0);
      chk("rst_les",   16'(LES),         16'hF);
      chk("rst_fv",    16'(frame_vld),   16'h0);
      chk("rst_err",   16'(err),         16'h0);
      chk("rst_stale", 16'(stale),       16'h0);
      RST = 1'b0;
      tick(2);

      // 1: plain scans of 1A2F, dp on digit 2
      fv_ref = fv_cnt;
      scan(16'h1A2F, 4'b0100, 4'b0000);
      chk("t1_fv1",   16'(fv_cnt - fv_ref), 16'd1);
      scan(16'h1A2F, 4'b0100, 4'b0000);
      chk("t1_fv2",   16'(fv_cnt - fv_ref), 16'd2);
      chk("t1_hexs",  HEXS,             16'h1A2F);
      chk("t1_pts",   16'(points),      16'h4);
      chk("t1_les",   16'(LES),         16'h0);
      chk("t1_err",   16'(err),         16'h0);
      chk("t1_stale", 16'(stale),       16'h0);

      // 2: digit 3 blank keeps its previous nibble
      fv_ref = fv_cnt;
      scan(16'h0B3C, 4'b0000, 4'b1000);
      chk("t2_fv",   16'(fv_cnt - fv_ref), 16'd1);
      chk("t2_hexs", HEXS,             16'h1B3C);
      chk("t2_les",  16'(LES),         16'h8);
      chk("t2_pts",  16'(points),      16'h0);
      chk("t2_err",  16'(err),         16'h0);

      // 3: glitching digit 0 settles to 0 with dp off
      fv_ref = fv_cnt;
      drive_digit(3, seg_of(4'h7, 1'b0), 8); blank_bus(2);
      drive_digit(2, seg_of(4'h8, 1'b0), 8); blank_bus(2);
      drive_digit(1, seg_of(4'h9, 1'b0), 8); blank_bus(2);
      drive_digit(0, 8'hF9, 1);
      drive_digit(0, 8'hA4, 1);
      drive_digit(0, 8'hF9, 1);
      drive_digit(0, 8'hC0, 8); blank_bus(2);
      chk("t3_fv",   16'(fv_cnt - fv_ref), 16'd1);
      chk("t3_hexs", HEXS,             16'h7890);
      chk("t3_les",  16'(LES),         16'h0);
      chk("t3_err",  16'(err),         16'h0);

      // 4: two digit enables low, then an illegal segment pattern
      fv_ref = fv_cnt;
      AN = 4'b1100; SEGMENT = 8'hC0; tick(10);
      blank_bus(2);
      chk("t4_err_an", 16'(err),         16'h1);
      chk("t4_fv_an",  16'(fv_cnt - fv_ref), 16'd0);
      drive_digit(0, 8'hAA, 8); blank_bus(2);
      drive_digit(1, seg_of(4'h6, 1'b0), 8); blank_bus(2);
      drive_digit(2, seg_of(4'h5, 1'b0), 8); blank_bus(2);
      drive_digit(3, seg_of(4'h4, 1'b0), 8); blank_bus(2);
      chk("t4_fv_seg", 16'(fv_cnt - fv_ref), 16'd1);
      chk("t4_hexs",   HEXS,             16'h4560);
      chk("t4_les",    16'(LES),         16'h0);
      chk("t4_err",    16'(err),         16'h1);

      // 5: scan stops long enough to go stale, then resumes
      blank_bus(66);
      chk("t5_stale1", 16'(stale),       16'h1);
      chk("t5_hold",   HEXS,             16'h4560);
      fv_ref = fv_cnt;
      scan(16'hCDE1, 4'b1010, 4'b0000);
      chk("t5_stale0", 16'(stale),       16'h0);
      chk("t5_fv",     16'(fv_cnt - fv_ref), 16'd1);
      chk("t5_hexs",   HEXS,             16'hCDE1);
      chk("t5_pts",    16'(points),      16'hA);
      chk("t5_err",    16'(err),         16'h1);

      // 6: reset after two of four digits, then one clean scan
      fv_ref = fv_cnt;
      drive_digit(0, seg_of(4'hF, 1'b0), 8); blank_bus(2);
      drive_digit(1, seg_of(4'hE, 1'b0), 8); blank_bus(1);
      RST = 1'b1;
      #1;
      chk("t6_hexs",  HEXS,             16'h0000);
      chk("t6_pts",   16'(points),      16'h0);
      chk("t6_les",   16'(LES),         16'hF);
      chk("t6_err",   16'(err),         16'h0);
      chk("t6_stale", 16'(stale),       16'h0);
      chk("t6_fv",    16'(frame_vld),   16'h0);
      tick(2);
      chk("t6_nofv",  16'(fv_cnt - fv_ref), 16'd0);
      RST = 1'b0;
      tick(2);
      fv_ref = fv_cnt;
      scan(16'h3795, 4'b0001, 4'b0000);
      chk("t6_fv1",   16'(fv_cnt - fv_ref), 16'd1);
      chk("t6_new",   HEXS,             16'h3795);
      chk("t6_npts",  16'(points),      16'h1);
      chk("t6_nles",  16'(LES),         16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
